// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   - lsu_size_t  : access-size encodings (byte, half, word, dword)
//   - lsu_state_t : LSU sequencing states
//   - sizeMask()  : right-aligned byte-lane mask for an access size
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // One bit per byte touched by an access of the given size, starting at lane 0.
  function automatic logic [7:0] sizeMask(input logic [1:0] size);
    case (size)
      SZ_B:    sizeMask = 8'h01;
      SZ_H:    sizeMask = 8'h03;
      SZ_W:    sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_lsu_if.sv
// Request/response bus between the MEM stage (master) and the LSU (slave).
//   req_*  : request from the pipeline (valid/ready handshake)
//   rsp_*  : single-cycle response pulse from the LSU
//
// Handshake: a request transfers in the cycle req_valid && req_ready are both
// high. The master keeps req_valid and every req_* field stable until that
// cycle. rsp_valid is a one-cycle pulse with no back-pressure; rsp_data,
// rsp_rd and rsp_err are only meaningful while rsp_valid is high.
interface riscv_dmem_lsu_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [4:0]        req_rd;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load extraction: shifts the raw memory word down to the addressed byte,
// keeps only the bytes of the access size and sign- or zero-extends the
// result to the full data width. Purely combinational.
//   rdWord     : raw memory word
//   off        : byte offset of the access inside the word
//   size       : access size (lsu_size_t encoding)
//   isUnsigned : 1 = zero-extend, 0 = sign-extend
//   loadData   : extended result
module lsu_load_align
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdWord,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              isUnsigned,
  output logic [DATA_W-1:0] loadData
);

  logic [DATA_W-1:0]        shifted;
  logic signed [DATA_W-1:0] topAligned;
  logic [6:0]               nBits;
  logic [6:0]               extAmt;

  // Truncate-and-extend is done by pushing the value to the top of the word
  // and shifting it back down, arithmetically for signed loads.
  always_comb begin
    shifted = rdWord >> {off, 3'b000};
    case (size)
      SZ_B:    nBits = 7'd8;
      SZ_H:    nBits = 7'd16;
      SZ_W:    nBits = 7'd32;
      default: nBits = 7'd64;
    endcase
    extAmt     = (nBits >= 7'(DATA_W)) ? 7'd0 : 7'(DATA_W) - nBits;
    topAligned = shifted << extAmt;
    if (isUnsigned) loadData = $unsigned(topAligned >> extAmt);
    else            loadData = $unsigned(topAligned >>> extAmt);
  end

endmodule

// File: rtl/riscv_dmem_lsu.sv
// Load/store unit between the MEM stage and a BRAM-style data memory port.
// Accepts one request at a time, steers store data/byte enables onto the
// addressed lanes, waits RD_LAT cycles for load data, extracts/extends it and
// returns a one-cycle response. Illegal size, out-of-range and (optionally)
// misaligned accesses fault without touching memory.
//
// Build option: define DMEM_MISALIGN_CHECK_EN to fault misaligned accesses;
// without it the low address bits are cleared to natural alignment.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus           : request/response bus (slave side)
//   mem_address0  : word address to memory
//   mem_ce0       : memory enable (accept cycle only)
//   mem_we0       : per-byte write enable
//   mem_d0        : lane-steered write data
//   mem_q0        : read data, valid RD_LAT cycles after the address cycle
//   dbgState      : current FSM state
module riscv_dmem_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_dmem_lsu_if.slave       bus,
  output logic [ADDR_W-1:0]     mem_address0,
  output logic                  mem_ce0,
  output logic [DATA_W/8-1:0]   mem_we0,
  output logic [DATA_W-1:0]     mem_d0,
  input  logic [DATA_W-1:0]     mem_q0,
  output lsu_state_t            dbgState
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  lsu_state_t state, stateNext;

  logic [1:0]        cnt;
  logic [OFF_W-1:0]  offQ;
  logic [1:0]        sizeQ;
  logic              unsQ;
  logic [DATA_W-1:0] rspData;
  logic [4:0]        rspRd;
  logic              rspErr;

  logic [OFF_W-1:0]  rawOff, off, lowMask;
  logic [2:0]        lowMask3;
  logic              misFault, rangeFault, sizeFault, fault;
  logic              accept, memGo;
  logic [BYTES-1:0]  weMask;
  logic [DATA_W-1:0] wdataMasked;
  logic [DATA_W-1:0] alignedData;

  // ---------------- request decode ----------------
  assign rawOff = bus.req_addr[OFF_W-1:0];

  always_comb begin
    case (bus.req_size)
      SZ_B:    lowMask3 = 3'd0;
      SZ_H:    lowMask3 = 3'd1;
      SZ_W:    lowMask3 = 3'd3;
      default: lowMask3 = 3'd7;
    endcase
  end
  assign lowMask = lowMask3[OFF_W-1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign off      = rawOff;
  assign misFault = |(rawOff & lowMask);
`else
  assign off      = rawOff & ~lowMask;
  assign misFault = 1'b0;
`endif

  assign rangeFault = |(bus.req_addr >> (ADDR_W + OFF_W));
  assign sizeFault  = (DATA_W == 32) && (bus.req_size == SZ_D);
  assign fault      = sizeFault | rangeFault | misFault;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign memGo         = accept && !fault;

  // ---------------- memory port (accept cycle only) ----------------
  assign weMask = BYTES'(sizeMask(bus.req_size));

  // Bytes above the access size are dropped so unselected lanes stay zero.
  always_comb begin
    wdataMasked = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (weMask[i]) wdataMasked[8*i +: 8] = bus.req_wdata[8*i +: 8];
    end
  end

  assign mem_ce0      = memGo;
  assign mem_address0 = memGo ? bus.req_addr[ADDR_W+OFF_W-1:OFF_W] : '0;
  assign mem_we0      = (memGo && bus.req_we) ? (weMask << off) : '0;
  assign mem_d0       = (memGo && bus.req_we) ? (wdataMasked << {off, 3'b000}) : '0;

  // ---------------- load extraction ----------------
  lsu_load_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .rdWord    (mem_q0),
    .off       (offQ),
    .size      (sizeQ),
    .isUnsigned(unsQ),
    .loadData  (alignedData)
  );

  // ---------------- FSM ----------------
  // Stores and faults respond the cycle after accept; loads spend RD_LAT
  // cycles in WAIT and capture mem_q0 in the last one.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = (fault || bus.req_we) ? RESP : WAIT;
      WAIT: if (cnt == 2'd0) stateNext = RESP;
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      offQ    <= '0;
      sizeQ   <= '0;
      unsQ    <= 1'b0;
      rspData <= '0;
      rspRd   <= '0;
      rspErr  <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        offQ    <= off;
        sizeQ   <= bus.req_size;
        unsQ    <= bus.req_unsigned;
        rspRd   <= bus.req_rd;
        rspErr  <= fault;
        rspData <= '0;
        cnt     <= 2'(RD_LAT - 1);
      end else if (state == WAIT) begin
        if (cnt == 2'd0) rspData <= alignedData;
        else             cnt     <= cnt - 2'd1;
      end
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rspData;
  assign bus.rsp_rd    = rspRd;
  assign bus.rsp_err   = rspErr;
  assign dbgState      = state;

endmodule

// File: tb/tb_riscv_dmem_lsu.sv
// Testbench for riscv_dmem_lsu (DATA_W=32, ADDR_W=5, RD_LAT=3).
// A BRAM emulation answers the memory port; expected results come from a
// byte-addressed reference memory and the access rules (size, extension,
// alignment, range, latency).
module tb_riscv_dmem_lsu;
  import riscv_lsu_pkg::*;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 3;
  localparam int BYTES     = DATA_W / 8;
  localparam int OFF_W     = $clog2(BYTES);
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam int MEM_BYTES = BYTES * MEM_WORDS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_dmem_lsu_if #(.DATA_W(DATA_W)) busIf ();

  logic [ADDR_W-1:0] mem_address0;
  logic              mem_ce0;
  logic [BYTES-1:0]  mem_we0;
  logic [DATA_W-1:0] mem_d0;
  logic [DATA_W-1:0] mem_q0;
  lsu_state_t        dbgState;

  riscv_dmem_lsu #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (busIf),
    .mem_address0(mem_address0),
    .mem_ce0     (mem_ce0),
    .mem_we0     (mem_we0),
    .mem_d0      (mem_d0),
    .mem_q0      (mem_q0),
    .dbgState    (dbgState)
  );

  // ---------------- BRAM emulation ----------------
  logic [DATA_W-1:0] bram   [MEM_WORDS];
  logic [DATA_W-1:0] rdPipe [RD_LAT];
  logic              memClear;

  always @(posedge clk) begin
    if (memClear) begin
      for (int w = 0; w < MEM_WORDS; w++) bram[w] <= '0;
    end else begin
      for (int i = 0; i < BYTES; i++)
        if (mem_ce0 && mem_we0[i]) bram[mem_address0][8*i +: 8] <= mem_d0[8*i +: 8];
    end
    // Idle cycles return garbage so a mistimed capture shows up.
    rdPipe[0] <= mem_ce0 ? bram[mem_address0] : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign mem_q0 = rdPipe[RD_LAT-1];

  // ---------------- reference model ----------------
  logic [7:0] refMem [MEM_BYTES];

  function automatic bit is_fault(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = 1 << size;
    if (DATA_W == 32 && size == 2'd3) return 1'b1;
    if (addr >= 32'(MEM_BYTES)) return 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((addr % 32'(n)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] eff_addr(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = 1 << size;
    return addr - (addr % 32'(n));
  endfunction

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with the DUT
  // idle again.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [4:0] rd, input string tag);
    bit                flt, got;
    int                n, lane, expCyc, ea;
    logic [BYTES-1:0]  expWe;
    logic [DATA_W-1:0] expD, expData;
    logic [63:0]       val;
    logic [31:0]       eaW;

    n       = 1 << size;
    flt     = is_fault(size, addr);
    eaW     = eff_addr(size, addr);
    ea      = int'(eaW);
    lane    = ea % BYTES;
    expCyc  = (flt || we) ? 1 : RD_LAT + 1;
    expWe   = '0;
    expD    = '0;
    expData = '0;
    got     = 1'b0;

    if (!flt && we) begin
      for (int i = 0; i < n; i++) begin
        expWe[lane+i]          = 1'b1;
        expD[8*(lane+i) +: 8]  = wdata[8*i +: 8];
      end
    end
    if (!flt && !we) begin
      val = '0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = refMem[ea+i];
      if (!uns && n < 8 && val[8*n-1]) val = val | (~64'd0 << (8*n));
      expData = val[DATA_W-1:0];
    end

    busIf.req_valid    = 1'b1;
    busIf.req_we       = we;
    busIf.req_size     = size;
    busIf.req_unsigned = uns;
    busIf.req_addr     = addr;
    busIf.req_wdata    = wdata[DATA_W-1:0];
    busIf.req_rd       = rd;
    #1;
    check({tag, "_ready"}, 64'(busIf.req_ready), 64'd1);
    check({tag, "_we0"}, 64'(mem_we0), 64'(expWe));
    if (flt || !we) check({tag, "_ce0"}, 64'(mem_ce0), 64'(!flt));
    if (!flt) check({tag, "_addr0"}, 64'(mem_address0), 64'(eaW[ADDR_W+OFF_W-1:OFF_W]));
    if (!flt && we) check({tag, "_d0"}, 64'(mem_d0), 64'(expD));

    @(posedge clk);
    #1;
    busIf.req_valid = 1'b0;
    busIf.req_addr  = $urandom;
    busIf.req_wdata = DATA_W'($urandom);
    busIf.req_rd    = 5'($urandom);
    if (!flt && we)
      for (int i = 0; i < n; i++) refMem[ea+i] = wdata[8*i +: 8];

    for (int c = 1; c <= expCyc + 2; c++) begin
      @(negedge clk);
      if (busIf.rsp_valid) begin
        got = 1'b1;
        check({tag, "_rsp_cycle"}, 64'(c), 64'(expCyc));
        check({tag, "_rsp_data"}, 64'(busIf.rsp_data), 64'(expData));
        check({tag, "_rsp_err"}, 64'(busIf.rsp_err), 64'(flt));
        check({tag, "_rsp_rd"}, 64'(busIf.rsp_rd), 64'(rd));
        break;
      end
      check({tag, "_busy_ready"}, 64'(busIf.req_ready), 64'd0);
      check({tag, "_busy_ce0"}, 64'(mem_ce0), 64'd0);
    end
    check({tag, "_rsp_seen"}, 64'(got), 64'd1);
    if (got) begin
      @(negedge clk);
      check({tag, "_rsp_one_cycle"}, 64'(busIf.rsp_valid), 64'd0);
      check({tag, "_ready_again"}, 64'(busIf.req_ready), 64'd1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int b = 0; b < MEM_BYTES; b++) refMem[b] = 8'h00;
    rst                = 1'b1;
    memClear           = 1'b1;
    busIf.req_valid    = 1'b1;
    busIf.req_we       = 1'b1;
    busIf.req_size     = SZ_W;
    busIf.req_unsigned = 1'b0;
    busIf.req_addr     = 32'h0;
    busIf.req_wdata    = '1;
    busIf.req_rd       = 5'd31;

    // Reset: a request held during reset must not be taken.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(busIf.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(busIf.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(busIf.rsp_data), 64'd0);
    check("rst_rsp_rd", 64'(busIf.rsp_rd), 64'd0);
    check("rst_rsp_err", 64'(busIf.rsp_err), 64'd0);
    check("rst_state", 64'(dbgState), 64'(IDLE));
    check("rst_ce0", 64'(mem_ce0), 64'd0);
    check("rst_we0", 64'(mem_we0), 64'd0);
    busIf.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    memClear = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_req(1'b1, SZ_W, 1'b0, 32'h08, 64'hDEADBEEF, 5'd1, "sw_8");
    do_req(1'b0, SZ_W, 1'b0, 32'h08, 64'h0, 5'd2, "lw_8");
    do_req(1'b1, SZ_B, 1'b0, 32'h13, 64'hA5A5A580, 5'd3, "sb_13");
    do_req(1'b0, SZ_B, 1'b0, 32'h13, 64'h0, 5'd4, "lb_13");
    do_req(1'b0, SZ_B, 1'b1, 32'h13, 64'h0, 5'd5, "lbu_13");
    do_req(1'b1, SZ_W, 1'b0, 32'h04, 64'h12348001, 5'd6, "sw_4");
    do_req(1'b0, SZ_H, 1'b0, 32'h06, 64'h0, 5'd7, "lh_6");
    do_req(1'b0, SZ_H, 1'b0, 32'h04, 64'h0, 5'd8, "lh_4");
    do_req(1'b0, SZ_W, 1'b0, 32'h05, 64'h0, 5'd9, "lw_5");
    do_req(1'b0, SZ_W, 1'b0, 32'h80, 64'h0, 5'd10, "lw_range");
    do_req(1'b1, SZ_W, 1'b0, 32'h80, 64'h11111111, 5'd11, "sw_range");
    do_req(1'b0, SZ_D, 1'b0, 32'h00, 64'h0, 5'd12, "ld_size");
    do_req(1'b1, SZ_H, 1'b0, 32'h7E, 64'hBEEF, 5'd13, "sh_top");
    do_req(1'b0, SZ_H, 1'b1, 32'h7E, 64'h0, 5'd14, "lhu_top");

    // Reset in C1 of a load aborts it: no response may follow.
    busIf.req_valid = 1'b1;
    busIf.req_we    = 1'b0;
    busIf.req_size  = SZ_W;
    busIf.req_addr  = 32'h08;
    busIf.req_rd    = 5'd20;
    @(posedge clk);
    #1;
    busIf.req_valid = 1'b0;
    rst             = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(busIf.req_ready), 64'd1);
    check("abort_rsp_valid", 64'(busIf.rsp_valid), 64'd0);
    for (int c = 0; c < RD_LAT + 3; c++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(busIf.rsp_valid), 64'd0);
    end

    // Randomized traffic.
    for (int k = 0; k < 200; k++) begin
      bit          rwe, runs;
      logic [1:0]  rsize;
      logic [31:0] raddr;
      logic [63:0] rwdata;
      rwe    = 1'($urandom_range(0, 1));
      runs   = 1'($urandom_range(0, 1));
      rsize  = 2'($urandom_range(0, 3));
      raddr  = 32'($urandom_range(0, MEM_BYTES + 7));
      if ($urandom_range(0, 19) == 0) raddr = $urandom;
      rwdata = {$urandom, $urandom};
      do_req(rwe, rsize, runs, raddr, rwdata, 5'($urandom), $sformatf("rnd%0d", k));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
